// File: rtl/router_rd_sched_if.sv
// Output byte stream of the router read scheduler: ready/valid plus packet tags.
interface router_rd_sched_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic [1:0] out_src;

  modport master (output out_valid, out_data, out_sop, out_eop, out_src, input out_ready);
  modport slave  (input out_valid, out_data, out_sop, out_eop, out_src, output out_ready);
endinterface

// File: rtl/router_rd_sched.sv
// Packet-granular round-robin read scheduler: drains three router FIFOs onto one
// ready/valid byte stream, whole packets at a time, through a 2-entry skid buffer.
module router_rd_sched #(
  parameter int unsigned STALL_MAX = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_out_0,
  input  logic              vld_out_1,
  input  logic              vld_out_2,
  input  logic [7:0]        dout_0,
  input  logic [7:0]        dout_1,
  input  logic [7:0]        dout_2,
  output logic              rd_en_0,
  output logic              rd_en_1,
  output logic              rd_en_2,
  router_rd_sched_if.master out_if,
  output logic              out_err,
  output logic [2:0]        grant
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HDR   = 2'd1;
  localparam logic [1:0] S_HWAIT = 2'd2;
  localparam logic [1:0] S_BODY  = 2'd3;
  localparam logic [7:0] STALL_LIM = 8'(STALL_MAX - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [6:0]  rem_q, rem_d;
  logic [7:0]  stall_q, stall_d;
  logic [2:0]  grant_q, grant_d;
  logic        err_q, err_d;
  logic        rd_q, rd_d;
  logic        rd_sop_q, rd_sop_d;
  logic        rd_eop_q, rd_eop_d;
  logic [1:0]  rd_src_q, rd_src_d;
  logic [11:0] ent0_q, ent0_d;
  logic [11:0] ent1_q, ent1_d;
  logic [1:0]  cnt_q, cnt_d;

  logic [2:0]  vld_vec;
  logic        vld_sel;
  logic [7:0]  dout_sel;
  logic [1:0]  cand1, cand2, pick;
  logic        pick_ok;
  logic        pop, push, credit, rd_fire;
  logic [11:0] push_ent;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign vld_vec = {vld_out_2, vld_out_1, vld_out_0};
  assign vld_sel = vld_vec[ptr_q];
  assign pop     = (cnt_q != 2'd0) && out_if.out_ready;
  assign push    = rd_q;
  // A byte leaving this cycle frees its slot in time, which keeps BODY at one byte per cycle.
  assign credit  = (({1'b0, cnt_q} + {2'b00, rd_q}) - {2'b00, pop}) < 3'd2;

  always_comb begin
    case (rd_src_q)
      2'd1:    dout_sel = dout_1;
      2'd2:    dout_sel = dout_2;
      default: dout_sel = dout_0;
    endcase
  end

  always_comb begin
    cand1   = inc3(ptr_q);
    cand2   = inc3(cand1);
    pick    = ptr_q;
    pick_ok = 1'b1;
    if (vld_vec[cand1])      pick = cand1;
    else if (vld_vec[cand2]) pick = cand2;
    else                     pick_ok = vld_vec[ptr_q];
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    stall_d  = stall_q;
    grant_d  = grant_q;
    err_d    = 1'b0;
    rd_fire  = 1'b0;
    rd_sop_d = 1'b0;
    rd_eop_d = 1'b0;
    rd_src_d = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (pick_ok) begin
          ptr_d   = pick;
          grant_d = 3'b001 << pick;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (vld_sel && credit) begin
          rd_fire  = 1'b1;
          rd_sop_d = 1'b1;
          state_d  = S_HWAIT;
        end
      end
      S_HWAIT: begin
        rem_d   = {1'b0, dout_sel[7:2]} + 7'd1;
        stall_d = '0;
        state_d = S_BODY;
      end
      default: begin
        if (rem_q != 7'd0) begin
          if (vld_sel && credit) begin
            rd_fire = 1'b1;
            rem_d   = rem_q - 7'd1;
            stall_d = '0;
            if (rem_q == 7'd1) begin
              rd_eop_d = 1'b1;
              grant_d  = '0;
              state_d  = S_IDLE;
            end
          end else if (!vld_sel) begin
            // Abort only on an empty cycle, so a final read can never coincide with it.
            if (stall_q >= STALL_LIM) begin
              err_d   = 1'b1;
              grant_d = '0;
              rem_d   = '0;
              stall_d = '0;
              state_d = S_IDLE;
            end else begin
              stall_d = stall_q + 8'd1;
            end
          end
        end
      end
    endcase
  end

  assign rd_d     = rd_fire;
  assign rd_en_0  = rd_fire && (ptr_q == 2'd0);
  assign rd_en_1  = rd_fire && (ptr_q == 2'd1);
  assign rd_en_2  = rd_fire && (ptr_q == 2'd2);
  assign push_ent = {rd_src_q, rd_eop_q, rd_sop_q, dout_sel};

  // Entry 0 is the output register; entry 1 is kept zero whenever it is unoccupied.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = push_ent;
        else               ent1_d = push_ent;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        ent1_d = '0;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = push_ent;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_ent;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= 2'd2;
      rem_q    <= '0;
      stall_q  <= '0;
      grant_q  <= '0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
      rd_sop_q <= 1'b0;
      rd_eop_q <= 1'b0;
      rd_src_q <= '0;
      ent0_q   <= '0;
      ent1_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      stall_q  <= stall_d;
      grant_q  <= grant_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      rd_sop_q <= rd_sop_d;
      rd_eop_q <= rd_eop_d;
      rd_src_q <= rd_src_d;
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_if.out_valid = (cnt_q != 2'd0);
  assign out_if.out_data  = ent0_q[7:0];
  assign out_if.out_sop   = ent0_q[8];
  assign out_if.out_eop   = ent0_q[9];
  assign out_if.out_src   = ent0_q[11:10];
  assign out_err          = err_q;
  assign grant            = grant_q;

endmodule

// File: tb/tb_router_rd_sched.sv
// Directed bench for router_rd_sched: three behavioural FIFOs feed the scheduler and
// every accepted output byte is compared against the packets loaded.
module tb_router_rd_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [7:0] dout_0, dout_1, dout_2;
  logic       rd_en_0, rd_en_1, rd_en_2;
  logic       out_err;
  logic [2:0] grant;

  router_rd_sched_if out_if ();

  router_rd_sched #(.STALL_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .dout_0(dout_0), .dout_1(dout_1), .dout_2(dout_2),
    .rd_en_0(rd_en_0), .rd_en_1(rd_en_1), .rd_en_2(rd_en_2),
    .out_if(out_if), .out_err(out_err), .grant(grant)
  );

  always #5 clk = ~clk;

  // FIFO model: contents written by the stimulus, read pointer owned by this block.
  logic [7:0] mem [3][1024];
  int wp [3];
  int rp [3];

  assign vld_out_0 = (wp[0] != rp[0]);
  assign vld_out_1 = (wp[1] != rp[1]);
  assign vld_out_2 = (wp[2] != rp[2]);

  always @(posedge clk) begin
    if (!rst) begin
      for (int f = 0; f < 3; f++) rp[f] <= wp[f];
    end else begin
      if (rd_en_0) begin dout_0 <= mem[0][rp[0]]; rp[0] <= rp[0] + 1; end
      if (rd_en_1) begin dout_1 <= mem[1][rp[1]]; rp[1] <= rp[1] + 1; end
      if (rd_en_2) begin dout_2 <= mem[2][rp[2]]; rp[2] <= rp[2] + 1; end
    end
  end

  // Monitor: accepted bytes, read strobes, error pulses, stalls, outstanding reads.
  logic [11:0] got [$];
  logic [11:0] exp_q [$];
  int rd_cnt [3];
  int err_cnt, err_bad_grant, stall_cyc, outst, max_outst, hold_bad, onehot_bad;
  logic [12:0] prev_word;
  logic        hold_pend = 1'b0;

  always @(posedge clk) begin
    logic acc;
    logic [12:0] cur;
    if (!rst) begin
      outst     = 0;
      hold_pend = 1'b0;
    end else begin
      acc = out_if.out_valid && out_if.out_ready;
      cur = {out_if.out_valid, out_if.out_src, out_if.out_eop, out_if.out_sop, out_if.out_data};
      if (acc) got.push_back(cur[11:0]);
      if (rd_en_0) rd_cnt[0]++;
      if (rd_en_1) rd_cnt[1]++;
      if (rd_en_2) rd_cnt[2]++;
      if ((int'(rd_en_0) + int'(rd_en_1) + int'(rd_en_2)) > 1) onehot_bad++;
      if (out_err) begin
        err_cnt++;
        if (grant != 3'b000) err_bad_grant++;
      end
      if (grant == 3'b100 && !vld_out_2) stall_cyc++;
      if (hold_pend && cur != prev_word) hold_bad++;
      hold_pend = out_if.out_valid && !out_if.out_ready;
      prev_word = cur;
      outst = outst + int'(rd_en_0 | rd_en_1 | rd_en_2) - int'(acc);
      if (outst > max_outst) max_outst = outst;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Loads one packet into FIFO f and appends the bytes it should produce to exp_q.
  task automatic applyStimulus(input int f, input logic [7:0] hdr, input int npay,
                               input logic [7:0] seed, input logic [7:0] par, input bit full);
    logic [1:0] src;
    logic [7:0] b;
    src = 2'(f);
    mem[f][wp[f]] = hdr;
    exp_q.push_back({src, 1'b0, 1'b1, hdr});
    for (int k = 0; k < npay; k++) begin
      b = seed + 8'(k);
      mem[f][wp[f] + 1 + k] = b;
      exp_q.push_back({src, 1'b0, 1'b0, b});
    end
    if (full) begin
      mem[f][wp[f] + 1 + npay] = par;
      exp_q.push_back({src, 1'b1, 1'b0, par});
    end
    wp[f] = wp[f] + 1 + npay + (full ? 1 : 0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic waitBytes(input string tag, input int target, input int budget, input bit toggle);
    logic [3:0] pat;
    int n;
    pat = 4'b1001;
    n = 0;
    while (got.size() < target && n < budget) begin
      @(negedge clk);
      if (toggle) out_if.out_ready = pat[n % 4];
      n++;
    end
    out_if.out_ready = 1'b1;
    checkOutput(tag, 32'(got.size()), 32'(target));
  endtask

  task automatic waitGrant(input string tag, input logic [2:0] g, input int budget);
    int n;
    n = 0;
    while (grant !== g && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(grant), 32'(g));
  endtask

  task automatic compareStream(input string tag, input int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got.size())
        checkOutput($sformatf("%s%0d", tag, i), 32'(got[base + i]), 32'(exp_q[i]));
    end
  endtask

  function automatic logic [19:0] out_vec();
    return {out_if.out_valid, out_if.out_data, out_if.out_sop, out_if.out_eop,
            out_if.out_src, out_err, grant, rd_en_2, rd_en_1, rd_en_0};
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, b_rd0, b_rd2, b_err, b_stall, b_errg;
    out_if.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 32'(out_vec()), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_outputs", 32'(out_vec()), 32'h0);

    // Single 8-payload packet from FIFO 0, latency and tags
    exp_q.delete(); base = got.size(); b_rd0 = rd_cnt[0];
    applyStimulus(0, 8'h20, 8, 8'h01, 8'hA5, 1'b1);
    @(negedge clk);
    checkOutput("t1_grant_hdr", 32'(grant), 32'(3'b001));
    checkOutput("t1_rd_en_hdr", 32'(rd_en_0), 32'h1);
    @(negedge clk);
    checkOutput("t1_hwait_quiet", 32'({rd_en_0, out_if.out_valid}), 32'h0);
    @(negedge clk);
    checkOutput("t1_first_byte", 32'({out_if.out_valid, out_if.out_sop, out_if.out_src, out_if.out_data}),
                32'({1'b1, 1'b1, 2'd0, 8'h20}));
    waitBytes("t1_count", base + 10, 100, 1'b0);
    compareStream("t1_byte", base);
    checkOutput("t1_rd_en_total", 32'(rd_cnt[0] - b_rd0), 32'd10);
    checkOutput("t1_grant_idle", 32'(grant), 32'h0);

    // Three FIFOs with two len=2 packets each: strict 0,1,2,0,1,2 order
    applyReset();
    exp_q.delete(); base = got.size();
    applyStimulus(0, 8'h08, 2, 8'h10, 8'hE0, 1'b1);
    applyStimulus(1, 8'h09, 2, 8'h20, 8'hE1, 1'b1);
    applyStimulus(2, 8'h0A, 2, 8'h30, 8'hE2, 1'b1);
    applyStimulus(0, 8'h08, 2, 8'h40, 8'hE3, 1'b1);
    applyStimulus(1, 8'h09, 2, 8'h50, 8'hE4, 1'b1);
    applyStimulus(2, 8'h0A, 2, 8'h60, 8'hE5, 1'b1);
    waitBytes("t2_count", base + 24, 200, 1'b0);
    compareStream("t2_byte", base);

    // 16-payload packet with out_ready toggling 1,0,0,1
    applyReset();
    exp_q.delete(); base = got.size();
    applyStimulus(0, 8'h40, 16, 8'h80, 8'h5A, 1'b1);
    waitBytes("t3_count", base + 18, 300, 1'b1);
    compareStream("t3_byte", base);
    checkOutput("t3_max_outstanding", 32'(max_outst), 32'd2);
    checkOutput("t3_hold_stable_viol", 32'(hold_bad), 32'd0);

    // len=0 packet in FIFO 1
    applyReset();
    exp_q.delete(); base = got.size();
    applyStimulus(1, 8'h01, 0, 8'h00, 8'h3C, 1'b1);
    waitBytes("t4_count", base + 2, 50, 1'b0);
    compareStream("t4_byte", base);

    // FIFO 2 runs dry mid-packet; abort after STALL_MAX empty cycles, FIFO 0 next
    applyReset();
    exp_q.delete(); base = got.size();
    b_err = err_cnt; b_stall = stall_cyc; b_errg = err_bad_grant; b_rd2 = rd_cnt[2];
    applyStimulus(2, 8'h42, 5, 8'h50, 8'h00, 1'b0);
    waitGrant("t5_grant2", 3'b100, 20);
    applyStimulus(0, 8'h04, 1, 8'h77, 8'h99, 1'b1);
    waitBytes("t5_count", base + 9, 200, 1'b0);
    compareStream("t5_byte", base);
    checkOutput("t5_err_pulses", 32'(err_cnt - b_err), 32'd1);
    checkOutput("t5_stall_cycles", 32'(stall_cyc - b_stall), 32'd4);
    checkOutput("t5_err_grant_nonzero", 32'(err_bad_grant - b_errg), 32'd0);
    checkOutput("t5_rd_en2_total", 32'(rd_cnt[2] - b_rd2), 32'd6);

    // Reset in the middle of a FIFO 1 packet, then arbitration restarts at FIFO 0
    applyReset();
    exp_q.delete();
    applyStimulus(1, 8'h41, 16, 8'hC0, 8'h12, 1'b1);
    waitGrant("t6_grant1", 3'b010, 20);
    repeat (6) @(negedge clk);
    checkOutput("t6_busy_before_reset", 32'(out_if.out_valid), 32'h1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_reset_outputs", 32'(out_vec()), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete(); base = got.size();
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h11, 1'b1);
    applyStimulus(1, 8'h01, 0, 8'h00, 8'h22, 1'b1);
    applyStimulus(2, 8'h02, 0, 8'h00, 8'h33, 1'b1);
    waitBytes("t6_count", base + 6, 100, 1'b0);
    compareStream("t6_byte", base);

    checkOutput("rd_en_onehot_viol", 32'(onehot_bad), 32'd0);
    checkOutput("hold_stable_viol", 32'(hold_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/router_rd_sched.md
# router_rd_sched

Packet-granular round-robin read scheduler for the 1x3 router's output side. Drains the three per-destination FIFOs onto one shared 8-bit output stream with ready/valid backpressure, whole packets at a time. It drives the FIFO read enables from their valid flags and parses each header to find packet length. Sits between the router outputs and a single downstream consumer.

## Interface
- STALL_MAX, 31: consecutive mid-packet cycles with the granted FIFO empty before the packet is aborted (range 1..255).
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- vld_out_0 / vld_out_1 / vld_out_2  in  1  FIFO n non-empty
- dout_0 / dout_1 / dout_2  in  8  FIFO n read data; valid the cycle after rd_en_n is sampled
- rd_en_0 / rd_en_1 / rd_en_2  out  1  FIFO n read strobe; at most one high per cycle
- out_ready  in  1  downstream accepts the byte when out_valid && out_ready
- out_valid  out  1  out_data holds a byte
- out_data  out  8  byte stream: header, payload, parity
- out_sop  out  1  qualifies the header byte
- out_eop  out  1  qualifies the parity byte
- out_src  out  2  source FIFO of the current byte (0..2)
- out_err  out  1  one-cycle pulse on packet abort
- grant  out  3  one-hot granted FIFO, 0 when idle

## Operation
- Packet format: header {len[7:2], addr[1:0]}, then len payload bytes, then 1 parity byte. Packet size is len+2 bytes. When len=0 the packet is header plus parity.
- States:
  - IDLE: pick the first n with vld_out_n high, searching from ptr+1 mod 3. Set grant, set ptr=n, go to HDR.
  - HDR: assert rd_en_n when vld_out_n and credit allow, then go to HWAIT.
  - HWAIT: one cycle. Header arrives; load rem = header[7:2] + 1 and go to BODY. No read is issued in HWAIT.
  - BODY: assert rd_en_n when rem>0, vld_out_n=1 and credit is available; rem decrements per read. When the read with rem=1 issues, clear grant and go to IDLE on the next edge.
- Arbitration is per packet. A granted FIFO keeps the grant until its parity read issues, even if other FIFOs are valid.
- Reset value of ptr is 2, so FIFO 0 wins first.
- Output buffering:
  - A 2-entry skid FIFO feeds the out_* registers.
  - Credit exists when skid occupancy plus in-flight reads is less than 2. This guarantees no byte is dropped when out_ready is low.
  - Each byte carries sop, eop and src tags.
- Stall counter (BODY only):
  - Increments on each cycle with vld_out_n=0 and rem>0; clears on any read.
  - When it reaches STALL_MAX: pulse out_err, clear grant, go to IDLE with ptr unchanged.
  - Bytes already issued still drain. The truncated packet carries no eop.
- vld_out low during HDR simply waits. The stall counter is not applied in HDR.
- addr field is passed through, not checked.

## Timing
- Reset values: all outputs 0, including grant=0. State is IDLE, ptr=2, rem=0, skid empty, stall=0. Reset mid-packet discards skid contents immediately.
- Latency with out_ready held high:
  - vld_out_n rises at edge k, grant at k+1, rd_en_n high in cycle k+1.
  - Header on out_data cycle k+3, with out_sop=1.
- Throughput: 1 byte/cycle in BODY when out_ready=1 and the FIFO is non-empty. Per-packet overhead is 2 bubble cycles (IDLE, HWAIT).
- out_data, out_valid and the tag outputs hold stable while out_valid && !out_ready.
- Back-to-back packets:
  - The next IDLE arbitration happens in the cycle after the last rd_en.
  - The same FIFO may be regranted only if the others are empty.
- Simultaneous events:
  - An abort and a final read in the same cycle resolve as normal completion, with no err.
  - A skid push and pop in the same cycle keep occupancy unchanged.

## Test plan
- After reset, FIFO 0 holds an 8-payload packet (header 0x20), out_ready=1 → 10 bytes out, out_sop on 0x20, out_eop on the 10th byte, out_src=0, grant 3'b001 then 0, rd_en_0 high for 10 cycles total.
- All three FIFOs hold len=2 packets at once → output order is FIFO 0, 1, 2, each 4 bytes contiguous, never interleaved. A second round resumes at 0.
- out_ready toggles 1,0,0,1 throughout a 16-payload packet → all 18 bytes arrive in order with none lost or duplicated, and at most 2 rd_en pulses outstanding.
- len=0 header 0x01 in FIFO 1 → 2 bytes out; the header has sop=1, the parity byte has eop=1, out_src=1.
- FIFO 2 goes empty after 5 of 16 payload bytes with STALL_MAX=4 → out_err pulses on the 4th empty cycle, grant clears, and a packet waiting in FIFO 0 is served next.
- rst driven low while BODY is mid-packet → on the next edge every output is 0; after rst returns high, arbitration restarts at FIFO 0.
